// File: rtl/vga_pkg.sv
// Shared VGA definitions: default coordinate/colour widths, screen size and
// the line rasteriser state encoding.
package vga_pkg;

  localparam int X_W_DEF  = 9;
  localparam int Y_W_DEF  = 8;
  localparam int C_W_DEF  = 3;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } line_state_t;

endpackage

// File: rtl/line_drawer.sv
// Bresenham line rasteriser: latches two endpoints and a colour, then emits
// one framebuffer pixel write per clock until the far endpoint is reached.
module line_drawer
  import vga_pkg::*;
#(
  parameter int X_W = X_W_DEF,
  parameter int Y_W = Y_W_DEF,
  parameter int C_W = C_W_DEF
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  input  logic           i_start,
  input  logic [X_W-1:0] i_x0,
  input  logic [Y_W-1:0] i_y0,
  input  logic [X_W-1:0] i_x1,
  input  logic [Y_W-1:0] i_y1,
  input  logic [C_W-1:0] i_color,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_plot,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic [C_W-1:0] o_color
);

  // Coordinates after the steep swap need room for either axis.
  localparam int CW = (X_W > Y_W) ? X_W : Y_W;
  // Error term: one sign bit plus one headroom bit over dx/dy.
  localparam int EW = X_W + 2;

  function automatic logic [CW-1:0] abs_diff(input logic [CW-1:0] a,
                                             input logic [CW-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  line_state_t state;

  logic [X_W-1:0]        x0_q, x1_q;
  logic [Y_W-1:0]        y0_q, y1_q;
  logic [C_W-1:0]        col_q;
  logic                  steep_q, yneg_q;
  logic [CW-1:0]         cx_q, cy_q, xe_q;
  logic [X_W-1:0]        dx_q, dy_q;
  logic signed [EW-1:0]  err_q;
  logic [X_W-1:0]        last_x;
  logic [Y_W-1:0]        last_y;
  logic [C_W-1:0]        last_c;

  logic [CW-1:0]         ex0, ey0, ex1, ey1;
  logic [CW-1:0]         sx0, sy0, sx1, sy1;
  logic [CW-1:0]         bx0, by0, bx1, by1;
  logic                  steep_c, swap_c;
  logic [X_W-1:0]        dx_c, dy_c;
  logic signed [EW-1:0]  err_init;
  logic signed [EW-1:0]  err_sum, err_next;
  logic                  ystep_c;
  logic [X_W-1:0]        pix_x;
  logic [Y_W-1:0]        pix_y;

  // Line setup from the latched endpoints: octant fold into a shallow,
  // left-to-right line and the initial Bresenham terms.
  always_comb begin
    ex0      = CW'(x0_q);
    ey0      = CW'(y0_q);
    ex1      = CW'(x1_q);
    ey1      = CW'(y1_q);
    steep_c  = abs_diff(ey0, ey1) > abs_diff(ex0, ex1);
    sx0      = steep_c ? ey0 : ex0;
    sy0      = steep_c ? ex0 : ey0;
    sx1      = steep_c ? ey1 : ex1;
    sy1      = steep_c ? ex1 : ey1;
    swap_c   = sx0 > sx1;
    bx0      = swap_c ? sx1 : sx0;
    by0      = swap_c ? sy1 : sy0;
    bx1      = swap_c ? sx0 : sx1;
    by1      = swap_c ? sy0 : sy1;
    dx_c     = X_W'(bx1 - bx0);
    dy_c     = X_W'(abs_diff(by0, by1));
    err_init = -$signed({2'b00, dx_c >> 1});
  end

  // Per-pixel error update and the un-folded pixel coordinate.
  always_comb begin
    err_sum  = err_q + $signed({2'b00, dy_q});
    ystep_c  = !err_sum[EW-1] && (err_sum != '0);
    err_next = ystep_c ? (err_sum - $signed({2'b00, dx_q})) : err_sum;
    pix_x    = steep_q ? X_W'(cy_q) : X_W'(cx_q);
    pix_y    = steep_q ? Y_W'(cx_q) : Y_W'(cy_q);
  end

  // FSM and Bresenham datapath; an async reset abandons any line in flight.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      col_q   <= '0;
      steep_q <= 1'b0;
      yneg_q  <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
      xe_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      last_x  <= '0;
      last_y  <= '0;
      last_c  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            x0_q  <= i_x0;
            y0_q  <= i_y0;
            x1_q  <= i_x1;
            y1_q  <= i_y1;
            col_q <= i_color;
            state <= INIT;
          end
        end
        INIT: begin
          steep_q <= steep_c;
          yneg_q  <= !(by0 < by1);
          cx_q    <= bx0;
          cy_q    <= by0;
          xe_q    <= bx1;
          dx_q    <= dx_c;
          dy_q    <= dy_c;
          err_q   <= err_init;
          state   <= DRAW;
        end
        DRAW: begin
          last_x <= pix_x;
          last_y <= pix_y;
          last_c <= col_q;
          if (cx_q == xe_q) begin
            state <= DONE;
          end else begin
            cx_q  <= cx_q + 1'b1;
            err_q <= err_next;
            if (ystep_c) cy_q <= yneg_q ? (cy_q - 1'b1) : (cy_q + 1'b1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status strobes decode the state; pixel outputs hold the last write.
  always_comb begin
    o_busy  = (state != IDLE);
    o_done  = (state == DONE);
    o_plot  = (state == DRAW);
    o_x     = o_plot ? pix_x : last_x;
    o_y     = o_plot ? pix_y : last_y;
    o_color = o_plot ? col_q : last_c;
  end

endmodule

// File: tb/tb_line_drawer.sv
// Directed bench for line_drawer: cycle-exact checks on short lines plus
// pixel-sequence checks on steep, diagonal, interrupted and reset cases.
module tb_line_drawer;

  logic       i_clk;
  logic       i_reset_n;
  logic       i_start;
  logic [8:0] i_x0, i_x1;
  logic [7:0] i_y0, i_y1;
  logic [2:0] i_color;
  logic       o_busy, o_done, o_plot;
  logic [8:0] o_x;
  logic [7:0] o_y;
  logic [2:0] o_color;

  int checks = 0;
  int errors = 0;

  int px [0:1023];
  int py [0:1023];
  int pc [0:1023];
  int n_pix;
  int n_done;
  bit timed_out;

  line_drawer dut (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_start  (i_start),
    .i_x0     (i_x0),
    .i_y0     (i_y0),
    .i_x1     (i_x1),
    .i_y1     (i_y1),
    .i_color  (i_color),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_plot   (o_plot),
    .o_x      (o_x),
    .o_y      (o_y),
    .o_color  (o_color)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Present a command and pulse i_start across one rising edge (edge k).
  task automatic start_line(input int x0, input int y0, input int x1,
                            input int y1, input int c);
    @(negedge i_clk);
    i_x0    = 9'(x0);
    i_y0    = 8'(y0);
    i_x1    = 9'(x1);
    i_y1    = 8'(y1);
    i_color = 3'(c);
    i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
  endtask

  // Record plotted pixels until o_done (plus one trailing cycle). When
  // poke_at > 0 a new command is pulsed in that sampled cycle.
  task automatic collect(input int limit, input int poke_at);
    n_pix     = 0;
    n_done    = 0;
    timed_out = 1'b1;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      @(negedge i_clk);
      i_start = 1'b0;
      if (o_plot) begin
        px[n_pix] = int'(o_x);
        py[n_pix] = int'(o_y);
        pc[n_pix] = int'(o_color);
        n_pix++;
      end
      if (cyc == poke_at) begin
        i_x0    = 9'd100;
        i_y0    = 8'd100;
        i_x1    = 9'd101;
        i_y1    = 8'd101;
        i_color = 3'd7;
        i_start = 1'b1;
      end
      if (o_done) begin
        n_done++;
        timed_out = 1'b0;
        break;
      end
    end
    @(negedge i_clk);
    i_start = 1'b0;
    if (o_done) n_done++;
    if (o_plot) n_pix++;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    i_start   = 1'b0;
    i_x0 = '0; i_y0 = '0; i_x1 = '0; i_y1 = '0; i_color = '0;
    #2;
    checks++;
    if ({o_busy, o_done, o_plot} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes: got busy/done/plot=%b expected 000", {o_busy, o_done, o_plot});
    end
    checks++;
    if ({o_x, o_y, o_color} !== 20'd0) begin
      errors++;
      $display("FAIL reset_pixel: got x=%0d y=%0d c=%0d expected 0 0 0", o_x, o_y, o_color);
    end
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    @(negedge i_clk);
    checks++;
    if ({o_busy, o_plot} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release_idle: got busy/plot=%b expected 00", {o_busy, o_plot});
    end
  endtask

  task automatic test_horizontal();
    bit ep, eb, ed;
    start_line(0, 0, 3, 0, 5);
    for (int c = 1; c <= 7; c++) begin
      @(negedge i_clk);
      ep = (c >= 2 && c <= 5);
      eb = (c >= 1 && c <= 6);
      ed = (c == 6);
      checks++;
      if ({o_plot, o_busy, o_done} !== {ep, eb, ed}) begin
        errors++;
        $display("FAIL horiz_ctrl cycle %0d: got plot/busy/done=%b expected %b", c, {o_plot, o_busy, o_done}, {ep, eb, ed});
      end
      if (ep) begin
        checks++;
        if (o_x !== 9'(c - 2) || o_y !== 8'd0 || o_color !== 3'd5) begin
          errors++;
          $display("FAIL horiz_pixel cycle %0d: got (%0d,%0d) c=%0d expected (%0d,0) c=5", c, o_x, o_y, o_color, c - 2);
        end
      end
    end
    checks++;
    if (o_x !== 9'd3 || o_y !== 8'd0 || o_color !== 3'd5) begin
      errors++;
      $display("FAIL horiz_hold: got (%0d,%0d) c=%0d expected (3,0) c=5", o_x, o_y, o_color);
    end
  endtask

  task automatic test_steep_reversed();
    int ex [0:5] = '{0, 0, 1, 1, 2, 2};
    int ey [0:5] = '{0, 1, 2, 3, 4, 5};
    start_line(2, 5, 0, 0, 3);
    collect(50, 0);
    checks++;
    if (timed_out || n_pix != 6 || n_done != 1) begin
      errors++;
      $display("FAIL steep_count: got pixels=%0d done=%0d timeout=%0d expected 6 1 0", n_pix, n_done, timed_out);
    end
    for (int i = 0; i < 6 && i < n_pix; i++) begin
      checks++;
      if (px[i] != ex[i] || py[i] != ey[i] || pc[i] != 3) begin
        errors++;
        $display("FAIL steep_pixel %0d: got (%0d,%0d) c=%0d expected (%0d,%0d) c=3", i, px[i], py[i], pc[i], ex[i], ey[i]);
      end
    end
  endtask

  task automatic test_diag_down();
    int ex [0:3] = '{0, 1, 2, 3};
    int ey [0:3] = '{3, 2, 1, 0};
    start_line(0, 3, 3, 0, 6);
    collect(50, 0);
    checks++;
    if (timed_out || n_pix != 4 || n_done != 1) begin
      errors++;
      $display("FAIL diag45_count: got pixels=%0d done=%0d timeout=%0d expected 4 1 0", n_pix, n_done, timed_out);
    end
    for (int i = 0; i < 4 && i < n_pix; i++) begin
      checks++;
      if (px[i] != ex[i] || py[i] != ey[i]) begin
        errors++;
        $display("FAIL diag45_pixel %0d: got (%0d,%0d) expected (%0d,%0d)", i, px[i], py[i], ex[i], ey[i]);
      end
    end
  endtask

  task automatic test_single_point();
    start_line(7, 9, 7, 9, 2);
    @(negedge i_clk);
    checks++;
    if ({o_busy, o_plot, o_done} !== 3'b100) begin
      errors++;
      $display("FAIL point_init: got busy/plot/done=%b expected 100", {o_busy, o_plot, o_done});
    end
    @(negedge i_clk);
    checks++;
    if (o_plot !== 1'b1 || o_done !== 1'b0 || o_x !== 9'd7 || o_y !== 8'd9 || o_color !== 3'd2) begin
      errors++;
      $display("FAIL point_pixel: got plot=%b done=%b (%0d,%0d) c=%0d expected 1 0 (7,9) c=2", o_plot, o_done, o_x, o_y, o_color);
    end
    @(negedge i_clk);
    checks++;
    if ({o_busy, o_plot, o_done} !== 3'b101) begin
      errors++;
      $display("FAIL point_done: got busy/plot/done=%b expected 101", {o_busy, o_plot, o_done});
    end
    @(negedge i_clk);
    checks++;
    if ({o_busy, o_done} !== 2'b00) begin
      errors++;
      $display("FAIL point_idle: got busy/done=%b expected 00", {o_busy, o_done});
    end
  endtask

  task automatic test_full_diagonal();
    int dev;
    start_line(319, 239, 0, 0, 1);
    collect(400, 0);
    checks++;
    if (timed_out || n_pix != 320 || n_done != 1) begin
      errors++;
      $display("FAIL diag_count: got pixels=%0d done=%0d timeout=%0d expected 320 1 0", n_pix, n_done, timed_out);
    end
    for (int i = 0; i < n_pix && i < 320; i++) begin
      dev = py[i] * 319 - px[i] * 239;
      if (dev < 0) dev = -dev;
      checks++;
      if (px[i] != i || dev > 319) begin
        errors++;
        $display("FAIL diag_pixel %0d: got (%0d,%0d) expected x=%0d within 1 of ideal y", i, px[i], py[i], i);
      end
    end
    checks++;
    if (n_pix < 1 || px[n_pix-1] != 319 || py[n_pix-1] != 239) begin
      errors++;
      $display("FAIL diag_last: got (%0d,%0d) expected (319,239)", px[n_pix > 0 ? n_pix-1 : 0], py[n_pix > 0 ? n_pix-1 : 0]);
    end
  endtask

  task automatic test_start_while_busy();
    start_line(10, 10, 14, 10, 4);
    collect(50, 3);
    checks++;
    if (timed_out || n_pix != 5 || n_done != 1) begin
      errors++;
      $display("FAIL busy_count: got pixels=%0d done=%0d timeout=%0d expected 5 1 0", n_pix, n_done, timed_out);
    end
    for (int i = 0; i < 5 && i < n_pix; i++) begin
      checks++;
      if (px[i] != 10 + i || py[i] != 10 || pc[i] != 4) begin
        errors++;
        $display("FAIL busy_pixel %0d: got (%0d,%0d) c=%0d expected (%0d,10) c=4", i, px[i], py[i], pc[i], 10 + i);
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge i_clk);
      checks++;
      if ({o_busy, o_plot} !== 2'b00) begin
        errors++;
        $display("FAIL busy_no_relaunch cycle %0d: got busy/plot=%b expected 00", c, {o_busy, o_plot});
      end
    end
  endtask

  task automatic test_start_held();
    @(negedge i_clk);
    i_x0 = 9'd1; i_y0 = 8'd1; i_x1 = 9'd1; i_y1 = 8'd1; i_color = 3'd3;
    i_start = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_x0 = 9'd3; i_y0 = 8'd4; i_x1 = 9'd3; i_y1 = 8'd4; i_color = 3'd6;
    @(negedge i_clk);
    checks++;
    if (o_plot !== 1'b1 || o_x !== 9'd1 || o_y !== 8'd1 || o_color !== 3'd3) begin
      errors++;
      $display("FAIL held_first: got plot=%b (%0d,%0d) c=%0d expected 1 (1,1) c=3", o_plot, o_x, o_y, o_color);
    end
    @(negedge i_clk);
    checks++;
    if (o_done !== 1'b1) begin
      errors++;
      $display("FAIL held_done: got done=%b expected 1", o_done);
    end
    @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL held_idle: got busy=%b expected 0", o_busy);
    end
    @(posedge i_clk);
    #1 i_start = 1'b0;
    @(negedge i_clk);
    checks++;
    if ({o_busy, o_plot} !== 2'b10) begin
      errors++;
      $display("FAIL held_relaunch: got busy/plot=%b expected 10", {o_busy, o_plot});
    end
    @(negedge i_clk);
    checks++;
    if (o_plot !== 1'b1 || o_x !== 9'd3 || o_y !== 8'd4 || o_color !== 3'd6) begin
      errors++;
      $display("FAIL held_second: got plot=%b (%0d,%0d) c=%0d expected 1 (3,4) c=6", o_plot, o_x, o_y, o_color);
    end
    @(negedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic test_reset_mid_draw();
    int ex [0:2] = '{2, 3, 4};
    int ey [0:2] = '{2, 2, 3};
    start_line(0, 0, 9, 0, 7);
    repeat (4) @(negedge i_clk);
    checks++;
    if (o_plot !== 1'b1 || o_x !== 9'd2) begin
      errors++;
      $display("FAIL rst_third_pixel: got plot=%b x=%0d expected 1 2", o_plot, o_x);
    end
    i_reset_n = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_done, o_plot} !== 3'b000 || {o_x, o_y, o_color} !== 20'd0) begin
      errors++;
      $display("FAIL rst_immediate: got busy/done/plot=%b x=%0d y=%0d c=%0d expected 000 0 0 0", {o_busy, o_done, o_plot}, o_x, o_y, o_color);
    end
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge i_clk);
      checks++;
      if ({o_busy, o_done, o_plot} !== 3'b000) begin
        errors++;
        $display("FAIL rst_abandon cycle %0d: got busy/done/plot=%b expected 000", c, {o_busy, o_done, o_plot});
      end
    end
    start_line(2, 2, 4, 3, 5);
    collect(50, 0);
    checks++;
    if (timed_out || n_pix != 3 || n_done != 1) begin
      errors++;
      $display("FAIL rst_fresh_count: got pixels=%0d done=%0d timeout=%0d expected 3 1 0", n_pix, n_done, timed_out);
    end
    for (int i = 0; i < 3 && i < n_pix; i++) begin
      checks++;
      if (px[i] != ex[i] || py[i] != ey[i] || pc[i] != 5) begin
        errors++;
        $display("FAIL rst_fresh_pixel %0d: got (%0d,%0d) c=%0d expected (%0d,%0d) c=5", i, px[i], py[i], pc[i], ex[i], ey[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_steep_reversed();
    test_diag_down();
    test_single_point();
    test_full_diagonal();
    test_start_while_busy();
    test_start_held();
    test_reset_mid_draw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_drawer.md
Name: line_drawer

Overview:
- Consumes the endpoint pair and colour latched by the UI register stage (x0/y0, x1/y1, colour).
- Rasterises a straight line between the endpoints using integer Bresenham.
- Emits one framebuffer pixel write per clock to the VGA adapter.
- Start/done handshake: the UI FSM launches a draw and waits for completion before accepting the next command.

Parameters:
- X_W, 9, x-coordinate width (0..319 screen)
- Y_W, 8, y-coordinate width (0..239 screen)
- C_W, 3, colour width

Ports:
- i_clk  in  1  system clock, all logic on rising edge
- i_reset_n  in  1  asynchronous active-low reset
- i_start  in  1  launch a draw; sampled only in IDLE
- i_x0  in  X_W  start x
- i_y0  in  Y_W  start y
- i_x1  in  X_W  end x
- i_y1  in  Y_W  end y
- i_color  in  C_W  line colour
- o_busy  out  1  high from the cycle after start is accepted until o_done clears
- o_done  out  1  one-cycle pulse after the last pixel
- o_plot  out  1  pixel write strobe, one pixel per cycle
- o_x  out  X_W  pixel x, valid when o_plot=1
- o_y  out  Y_W  pixel y, valid when o_plot=1
- o_color  out  C_W  pixel colour, valid when o_plot=1

Behaviour:
- Reset (async, i_reset_n=0): state IDLE; o_busy, o_done, o_plot, o_x, o_y, o_color all 0; internal registers 0.
- Reset asserted mid-draw abandons the line immediately. No further o_plot and no o_done pulse.
- FSM states: IDLE, INIT, DRAW, DONE.
- IDLE: when i_start=1, latch all endpoint and colour inputs, then go to INIT. Inputs are not sampled again until the next IDLE.
- INIT (1 cycle):
  - steep = |y1-y0| > |x1-x0|; if steep, swap x with y for both endpoints.
  - If x0 > x1 after that, swap the endpoints.
  - dx = x1-x0; dy = |y1-y0|; err = -(dx>>1); ystep = +1 if y0<y1 else -1.
  - Cursor (cx,cy) = (x0,y0). Go to DRAW.
- DRAW, one pixel per cycle:
  - o_plot=1; (o_x,o_y) = steep ? (cy,cx) : (cx,cy); o_color = latched colour.
  - If cx==x1, go to DONE.
  - Otherwise cx+=1; if err+dy > 0 then cy+=ystep and err = err+dy-dx, else err = err+dy.
- DONE (1 cycle): o_done=1, o_plot=0, then IDLE.
- o_busy = 1 in INIT, DRAW and DONE.
- Latency: i_start high at edge k gives INIT in cycle k+1 and first o_plot in cycle k+2. Pixel count N = max(|dx|,|dy|)+1. Last o_plot is in cycle k+N+1, o_done in cycle k+N+2; the next start is accepted at edge k+N+3.
- Widths: after the steep swap, the swapped coordinates and cursor use max(X_W,Y_W) bits. dx and dy are unsigned, X_W bits. err is signed, X_W+2 bits, with no overflow for a 320x240 screen. Pixel outputs are truncated back to X_W/Y_W, which is lossless by construction.
- o_x, o_y and o_color hold their last value when o_plot=0.
- Boundaries:
  - i_start while busy is ignored, with no effect on the current line.
  - i_start held high across DONE begins a new draw on the first IDLE cycle.
  - x0==x1 and y0==y1 gives exactly one pixel.
  - Vertical, horizontal and 45-degree lines need no special path.
  - Endpoints are not range-checked; the caller guarantees x<320 and y<240.

Decomposition:
- Shared package vga_pkg: X_W, Y_W, C_W defaults, SCREEN_W=320, SCREEN_H=240, and the line_state_t enum {IDLE, INIT, DRAW, DONE}.
- No sub-module: FSM plus Bresenham datapath in one module. An optional combinational helper abs_diff may live in vga_pkg as a function.

Test Plan:
- Horizontal: (0,0)->(3,0), colour 5, start at edge 0 -> o_plot in cycles 2..5 with (0,0),(1,0),(2,0),(3,0), colour 5; o_done in cycle 6 only; o_busy in cycles 1..6.
- Steep reversed: (2,5)->(0,0) -> six pixels in order (0,0),(0,1),(1,2),(1,3),(2,4),(2,5); then one o_done pulse.
- Single point: (7,9)->(7,9) -> one o_plot at (7,9) in cycle 2; o_done in cycle 3.
- Full diagonal: (319,239)->(0,0) -> 320 pixels, each x exactly once, last pixel (319,239). Every pixel lies within 1 of the ideal line; o_done once.
- Start while busy: pulse i_start with new endpoints during DRAW -> the current line completes unchanged and the new endpoints are not drawn.
- Reset mid-draw: drop i_reset_n during the 3rd pixel of a 10-pixel line -> outputs are 0 immediately; no o_done. After release, i_start draws a fresh line correctly.
